// File: rtl/imem_fetch_arbiter.sv
// Shares the instruction-memory read port between CPU fetch and a debug port.
// Optional stall counter output perf_fetch_stall is built when IMEM_ARB_PERF_EN is defined.
module imem_fetch_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_LIMIT  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic        fetch_err,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  output logic        dbg_valid,
  output logic [31:0] dbg_data,
  output logic        dbg_err,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_instr,
  output logic        busy
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_fetch_stall
`endif
);

  // Handshake: a requester raises req with a stable address and keeps both
  // until its valid pulse; err qualifies valid for that single cycle. A req
  // still high on the edge after valid is treated as a fresh request.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FAULT  = 2'd2
  } state_t;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DBG   = 1'b1
  } port_t;

  localparam logic [3:0]  COUNT_LAST   = 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] ADDR_LIMIT_W = 32'(ADDR_LIMIT);

  state_t      state;
  port_t       owner;
  port_t       rr_ptr;
  logic [3:0]  count;

  logic        grant_any;
  port_t       grant_port;
  logic [31:0] grant_addr;
  logic        grant_legal;

  always_comb begin
    grant_any  = fetch_req | dbg_req;
    grant_port = PORT_FETCH;
    if (fetch_req && dbg_req) begin
      grant_port = rr_ptr;
    end else if (dbg_req) begin
      grant_port = PORT_DBG;
    end
    grant_addr  = (grant_port == PORT_DBG) ? dbg_addr : fetch_addr;
    grant_legal = (grant_addr[1:0] == 2'b00) && (grant_addr < ADDR_LIMIT_W);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= PORT_FETCH;
      rr_ptr      <= PORT_FETCH;
      count       <= 4'd0;
      mem_addr    <= 32'd0;
      fetch_valid <= 1'b0;
      fetch_instr <= 32'd0;
      fetch_err   <= 1'b0;
      dbg_valid   <= 1'b0;
      dbg_data    <= 32'd0;
      dbg_err     <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      dbg_valid   <= 1'b0;
      dbg_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner  <= grant_port;
            rr_ptr <= (grant_port == PORT_FETCH) ? PORT_DBG : PORT_FETCH;
            if (grant_legal) begin
              mem_addr <= grant_addr;
              count    <= 4'd0;
              state    <= ACCESS;
            end else begin
              state <= FAULT;
            end
          end
        end
        ACCESS: begin
          count <= count + 4'd1;
          // mem_addr has been stable for WAIT_CYCLES edges on this edge
          if (count == COUNT_LAST) begin
            if (owner == PORT_FETCH) begin
              fetch_instr <= mem_instr;
              fetch_valid <= 1'b1;
            end else begin
              dbg_data  <= mem_instr;
              dbg_valid <= 1'b1;
            end
            state <= IDLE;
          end
        end
        FAULT: begin
          if (owner == PORT_FETCH) begin
            fetch_instr <= 32'd0;
            fetch_valid <= 1'b1;
            fetch_err   <= 1'b1;
          end else begin
            dbg_data  <= 32'd0;
            dbg_valid <= 1'b1;
            dbg_err   <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef IMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetch_stall <= 32'd0;
    end else if (fetch_req && !fetch_valid) begin
      perf_fetch_stall <= perf_fetch_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed scoreboard bench for imem_fetch_arbiter: one instance with a
// one-cycle memory delay and one with a three-cycle delay.
module tb_imem_fetch_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  // instance with WAIT_CYCLES = 1
  logic        fetch_req, dbg_req;
  logic [31:0] fetch_addr, dbg_addr;
  logic        fetch_valid, fetch_err, dbg_valid, dbg_err, busy;
  logic [31:0] fetch_instr, dbg_data, mem_addr, mem_instr;
  logic        use_fixed;
  logic [31:0] fixed_instr;
  assign mem_instr = use_fixed ? fixed_instr : (32'hC0DE_0000 | mem_addr);

  // instance with WAIT_CYCLES = 3
  logic        f3_req, d3_req;
  logic [31:0] f3_addr, d3_addr;
  logic        f3_valid, f3_err, d3_valid, d3_err, busy3;
  logic [31:0] f3_instr, d3_data, mem3_addr, mem3_instr;
  assign mem3_instr = 32'h5EED_0000 | mem3_addr;

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] perf1, perf3;
`endif

  imem_fetch_arbiter #(.WAIT_CYCLES(1), .ADDR_LIMIT(4096)) u_dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_err(fetch_err),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_err(dbg_err),
    .mem_addr(mem_addr), .mem_instr(mem_instr), .busy(busy)
`ifdef IMEM_ARB_PERF_EN
    , .perf_fetch_stall(perf1)
`endif
  );

  imem_fetch_arbiter #(.WAIT_CYCLES(3), .ADDR_LIMIT(4096)) u_dut3 (
    .clk(clk), .reset(reset),
    .fetch_req(f3_req), .fetch_addr(f3_addr),
    .fetch_valid(f3_valid), .fetch_instr(f3_instr), .fetch_err(f3_err),
    .dbg_req(d3_req), .dbg_addr(d3_addr),
    .dbg_valid(d3_valid), .dbg_data(d3_data), .dbg_err(d3_err),
    .mem_addr(mem3_addr), .mem_instr(mem3_instr), .busy(busy3)
`ifdef IMEM_ARB_PERF_EN
    , .perf_fetch_stall(perf3)
`endif
  );

  int total  = 0;
  int passed = 0;
  logic        prev_busy;
  logic [32:0] fetch_exp_q[$];
  logic [32:0] dbg_exp_q[$];
  logic [31:0] addr_exp_q[$];
  logic [32:0] f3_exp_q[$];
  logic [32:0] d3_exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    fetch_req = 1'b0;
    dbg_req   = 1'b0;
    f3_req    = 1'b0;
    d3_req    = 1'b0;
    repeat (2) @(negedge clk);
    reset     = 1'b1;
    prev_busy = 1'b0;
  endtask

  // Scoreboard monitor for the WAIT_CYCLES=1 instance over n cycles.
  task automatic monitor(input int n, input bit drop);
    logic [32:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("valid_overlap", {31'd0, fetch_valid & dbg_valid}, 32'd0);
      if (fetch_valid) begin
        if (fetch_exp_q.size() == 0) begin
          check("fetch_spurious_valid", {31'd0, fetch_valid}, 32'd0);
        end else begin
          e = fetch_exp_q.pop_front();
          check("fetch_instr", fetch_instr, e[31:0]);
          check("fetch_err", {31'd0, fetch_err}, {31'd0, e[32]});
        end
        if (drop) fetch_req = 1'b0;
      end
      if (dbg_valid) begin
        if (dbg_exp_q.size() == 0) begin
          check("dbg_spurious_valid", {31'd0, dbg_valid}, 32'd0);
        end else begin
          e = dbg_exp_q.pop_front();
          check("dbg_data", dbg_data, e[31:0]);
          check("dbg_err", {31'd0, dbg_err}, {31'd0, e[32]});
        end
        if (drop) dbg_req = 1'b0;
      end
      if (busy && !prev_busy) begin
        if (addr_exp_q.size() == 0) check("spurious_grant_busy", {31'd0, busy}, 32'd0);
        else check("grant_mem_addr", mem_addr, addr_exp_q.pop_front());
      end
      prev_busy = busy;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] e;
    use_fixed   = 1'b1;
    fixed_instr = 32'h8C01_0004;
    fetch_addr  = 32'h10;
    dbg_addr    = 32'h0;
    f3_addr     = 32'h0;
    d3_addr     = 32'h0;
    f3_req      = 1'b0;
    d3_req      = 1'b0;
    dbg_req     = 1'b0;
    fetch_req   = 1'b1;
    reset       = 1'b0;
    prev_busy   = 1'b0;

    // reset held with a pending fetch request
    repeat (2) @(negedge clk);
    check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_fetch_instr", fetch_instr, 32'd0);
    check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    check("rst_dbg_valid", {31'd0, dbg_valid}, 32'd0);
    check("rst_dbg_data", dbg_data, 32'd0);
    check("rst_dbg_err", {31'd0, dbg_err}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // first legal fetch after reset release
    reset = 1'b1;
    fetch_exp_q.push_back({1'b0, 32'h8C01_0004});
    addr_exp_q.push_back(32'h10);
    monitor(3, 1'b1);
    check("fetch_instr_hold", fetch_instr, 32'h8C01_0004);
    use_fixed = 1'b0;

    // both requesters held high: fetch, dbg, fetch
    do_reset();
    fetch_addr = 32'h0;
    dbg_addr   = 32'h8;
    fetch_req  = 1'b1;
    dbg_req    = 1'b1;
    fetch_exp_q.push_back({1'b0, 32'hC0DE_0000});
    dbg_exp_q.push_back({1'b0, 32'hC0DE_0008});
    fetch_exp_q.push_back({1'b0, 32'hC0DE_0000});
    addr_exp_q.push_back(32'h0);
    addr_exp_q.push_back(32'h8);
    addr_exp_q.push_back(32'h0);
    monitor(6, 1'b0);
    fetch_req = 1'b0;
    dbg_req   = 1'b0;
    monitor(2, 1'b1);
    check("rr_fetch_q_empty", 32'(fetch_exp_q.size()), 32'd0);
    check("rr_dbg_q_empty", 32'(dbg_exp_q.size()), 32'd0);
    check("rr_addr_q_empty", 32'(addr_exp_q.size()), 32'd0);

    // misaligned fetch faults, mem_addr stays at 0x0
    fetch_addr = 32'h6;
    fetch_req  = 1'b1;
    fetch_exp_q.push_back({1'b1, 32'h0});
    addr_exp_q.push_back(32'h0);
    monitor(3, 1'b1);

    // debug address at the limit faults
    dbg_addr = 32'h1000;
    dbg_req  = 1'b1;
    dbg_exp_q.push_back({1'b1, 32'h0});
    addr_exp_q.push_back(32'h0);
    monitor(3, 1'b1);

    // last legal word
    dbg_addr = 32'hFFC;
    dbg_req  = 1'b1;
    dbg_exp_q.push_back({1'b0, 32'hC0DE_0FFC});
    addr_exp_q.push_back(32'hFFC);
    monitor(3, 1'b1);

    // aligned but far out of range
    fetch_addr = 32'hFFFF_FFFC;
    fetch_req  = 1'b1;
    fetch_exp_q.push_back({1'b1, 32'h0});
    addr_exp_q.push_back(32'hFFC);
    monitor(3, 1'b1);
    check("dbg_data_hold", dbg_data, 32'hC0DE_0FFC);
    check("fault_fetch_q_empty", 32'(fetch_exp_q.size()), 32'd0);
    check("fault_dbg_q_empty", 32'(dbg_exp_q.size()), 32'd0);
    check("fault_addr_q_empty", 32'(addr_exp_q.size()), 32'd0);

    // three-cycle wait, owner address changes mid-access
    @(negedge clk);
    f3_addr = 32'h40;
    f3_req  = 1'b1;
    f3_exp_q.push_back({1'b0, 32'h5EED_0040});
    @(negedge clk);
    check("w3_mem_addr_1", mem3_addr, 32'h40);
    check("w3_busy", {31'd0, busy3}, 32'd1);
    check("w3_valid_1", {31'd0, f3_valid}, 32'd0);
    f3_addr = 32'h20;
    @(negedge clk);
    check("w3_mem_addr_2", mem3_addr, 32'h40);
    check("w3_valid_2", {31'd0, f3_valid}, 32'd0);
    @(negedge clk);
    check("w3_mem_addr_3", mem3_addr, 32'h40);
    check("w3_valid_3", {31'd0, f3_valid}, 32'd0);
    @(negedge clk);
    check("w3_valid", {31'd0, f3_valid}, 32'd1);
    if (f3_valid && f3_exp_q.size() > 0) begin
      e = f3_exp_q.pop_front();
      check("w3_instr", f3_instr, e[31:0]);
      check("w3_err", {31'd0, f3_err}, {31'd0, e[32]});
    end
    f3_req = 1'b0;
    @(negedge clk);
    check("w3_valid_drop", {31'd0, f3_valid}, 32'd0);
    check("w3_idle", {31'd0, busy3}, 32'd0);

    // reset in the middle of an access abandons it
    f3_addr = 32'h80;
    f3_req  = 1'b1;
    @(negedge clk);
    check("ra_busy", {31'd0, busy3}, 32'd1);
    f3_req = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("ra_busy_cleared", {31'd0, busy3}, 32'd0);
    check("ra_mem_addr", mem3_addr, 32'd0);
    check("ra_instr", f3_instr, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("ra_valid_quiet", {31'd0, f3_valid}, 32'd0);
      @(negedge clk);
    end

    // debug holds the memory while fetch waits
    do_reset();
    d3_addr = 32'h4;
    d3_req  = 1'b1;
    d3_exp_q.push_back({1'b0, 32'h5EED_0004});
    @(negedge clk);
    f3_addr = 32'h8;
    f3_req  = 1'b1;
    f3_exp_q.push_back({1'b0, 32'h5EED_0008});
    repeat (2) begin
      @(negedge clk);
      check("st_fetch_wait", {31'd0, f3_valid}, 32'd0);
    end
    @(negedge clk);
    check("st_dbg_valid", {31'd0, d3_valid}, 32'd1);
    if (d3_valid && d3_exp_q.size() > 0) begin
      e = d3_exp_q.pop_front();
      check("st_dbg_data", d3_data, e[31:0]);
      check("st_dbg_err", {31'd0, d3_err}, {31'd0, e[32]});
    end
`ifdef IMEM_ARB_PERF_EN
    check("perf_at_dbg_valid", perf3, 32'd3);
`endif
    d3_req = 1'b0;
    @(negedge clk);
    check("st_fetch_grant_addr", mem3_addr, 32'h8);
`ifdef IMEM_ARB_PERF_EN
    check("perf_at_grant", perf3, 32'd4);
`endif
    repeat (2) @(negedge clk);
    @(negedge clk);
    check("st_fetch_valid", {31'd0, f3_valid}, 32'd1);
    check("st_dbg_quiet", {31'd0, d3_valid}, 32'd0);
    if (f3_valid && f3_exp_q.size() > 0) begin
      e = f3_exp_q.pop_front();
      check("st_fetch_instr", f3_instr, e[31:0]);
      check("st_fetch_err", {31'd0, f3_err}, {31'd0, e[32]});
    end
`ifdef IMEM_ARB_PERF_EN
    check("perf_at_fetch_valid", perf3, 32'd7);
`endif
    f3_req = 1'b0;
    @(negedge clk);
`ifdef IMEM_ARB_PERF_EN
    check("perf_stopped", perf3, 32'd7);
`endif
    check("st_f3_q_empty", 32'(f3_exp_q.size()), 32'd0);
    check("st_d3_q_empty", 32'(d3_exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imem_fetch_arbiter.md
Name: imem_fetch_arbiter

Overview:
Sequencing controller in front of the 1024-word instruction memory. It shares the memory read port between the CPU fetch stage and a debug/program-inspect port. Each request is checked for alignment and range, then the block holds the memory address stable for a fixed number of cycles to cover the memory's output delay. It returns the instruction with a one-cycle valid pulse. Sits between the PC/fetch logic and the instruction memory.

Parameters:
WAIT_CYCLES, 1, cycles mem_addr is held before mem_instr is sampled; legal range 1..15
ADDR_LIMIT, 4096, byte-address bound; addresses >= ADDR_LIMIT fault

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
fetch_req  input  1  CPU fetch request; held with fetch_addr until fetch_valid
fetch_addr  input  32  CPU byte address
fetch_valid  output  1  one-cycle pulse, fetch result available
fetch_instr  output  32  fetched instruction; held until next fetch_valid
fetch_err  output  1  qualifies fetch_valid: misaligned or out-of-range access
dbg_req  input  1  debug read request; held with dbg_addr until dbg_valid
dbg_addr  input  32  debug byte address
dbg_valid  output  1  one-cycle pulse, debug result available
dbg_data  output  32  debug read data; held until next dbg_valid
dbg_err  output  1  qualifies dbg_valid, same fault rules
mem_addr  output  32  address to instruction memory (byte address)
mem_instr  input  32  instruction memory data
busy  output  1  high while state != IDLE

Behaviour:
- Reset (reset==0 at a rising edge) forces the following regardless of state: state=IDLE, mem_addr=0, all valid/err=0, fetch_instr=0, dbg_data=0, rr_ptr=FETCH, count=0. Any in-flight access is abandoned with no valid pulse.
- States: IDLE, ACCESS, FAULT.
- IDLE grant selection: only one req high -> that port. Both high -> port named by rr_ptr. rr_ptr toggles to the other port after every grant, including faulting grants.
- On the granting edge, the block latches owner and address.
  - Address legal (addr[1:0]==0 and addr<ADDR_LIMIT) -> mem_addr<=addr, count<=0, go ACCESS.
  - Otherwise -> FAULT; mem_addr unchanged.
- ACCESS: mem_addr held constant. count increments each edge. On the edge where count==WAIT_CYCLES-1:
  - owner's data reg<=mem_instr, owner's valid<=1, err<=0;
  - go IDLE.
- FAULT: one edge later, owner's data reg<=0, valid<=1, err<=1, go IDLE.
- Latency from the grant edge E0 to valid high: after edge E0+WAIT_CYCLES for a legal access; after edge E0+1 for a fault.
- Valid lasts exactly one cycle. err is meaningful only while valid is high and clears with valid.
- IDLE is entered in the same cycle valid is high, so back-to-back grants are allowed. A requester must drop req, or present a new address, in its valid cycle. A req still high at the next edge is a new request.
- Non-owner req is ignored until IDLE. Its valid never pulses spuriously.
- Address changes by the owner during ACCESS are ignored; the latched address is used.
- Word index at the memory is mem_addr/4 and is the memory's concern; the arbiter passes byte addresses.

Optional Feature:
Macro IMEM_ARB_PERF_EN.
- Defined: adds output perf_fetch_stall [31:0] with reset 0. It increments (wrapping at 2^32) every cycle fetch_req==1 and fetch_valid==0.
- Undefined: no port, no counter logic; all other behaviour identical.

Test Plan:
- Reset low 2 cycles with fetch_req=1 -> all outputs 0, busy=0. Release, mem_instr=0x8C010004, fetch_addr=0x10 -> mem_addr=0x10 after 1 edge; fetch_valid pulse 1 cycle later (WAIT_CYCLES=1) with fetch_instr=0x8C010004, fetch_err=0.
- Both req high continuously, fetch_addr=0x0, dbg_addr=0x8 -> grants alternate fetch, dbg, fetch; mem_addr sequence 0x0, 0x8, 0x0; valids never overlap.
- fetch_addr=0x6 -> no mem_addr change, fetch_valid with fetch_err=1, fetch_instr=0. dbg_addr=0x1000 -> dbg_err=1.
- WAIT_CYCLES=3: mem_addr stable 3 cycles; fetch_addr changed mid-access to 0x20 -> result comes from the original address.
- Reset asserted during ACCESS -> no valid pulse, state IDLE, busy=0 next cycle.
- IMEM_ARB_PERF_EN defined, dbg holds memory with fetch_req waiting 4 cycles -> perf_fetch_stall=4 before fetch granted.
